interp_phase_sequencer: RTL and testbench

//  Sequences the 4-tap x 16-phase polyphase interpolation FIR: accepts input samples through a

---
 rtl/interp_pkg.sv | 19 +
 rtl/interp_tag_pipe.sv | 40 ++++
 rtl/interp_phase_sequencer.sv | 134 +++++++++++++
 tb/tb_interp_phase_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared constants and state type for the polyphase interpolator
// Consumed by interp_phase_sequencer, interp_tag_pipe and the polyphase FIR.
package interp_pkg;

  localparam int OSF            = 16;  // phases per input sample
  localparam int SEL_W          = 5;   // FIR phase-select width
  localparam int PIPE_LAT       = 4;   // first cycle of a select -> coherent FIR output
  localparam int DEF_PHASE_HOLD = 3;   // default cycles per phase select
  localparam int DEF_CNT_W      = 16;  // default underrun counter width

  // Select value the FIR maps to an all-zero coefficient row.
  localparam logic [SEL_W-1:0] NULL_SEL = SEL_W'(OSF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/interp_tag_pipe.sv
// rtl/interp_tag_pipe.sv - fixed-depth {valid,phase} delay matching the FIR settle latency
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_valid     tag valid entering the pipe this cycle
//   push_phase     phase carried with the tag
//   tag_valid      tag valid leaving the pipe (DEPTH cycles after push)
//   tag_phase      phase leaving the pipe
module interp_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  input  logic [W-1:0] push_phase,
  output logic         tag_valid,
  output logic [W-1:0] tag_phase
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     ph [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) ph[i] <= '0;
    end else begin
      vld[0] <= push_valid;
      ph[0]  <= push_phase;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        ph[i]  <= ph[i-1];
      end
    end
  end

  assign tag_valid = vld[DEPTH-1];
  assign tag_phase = ph[DEPTH-1];

endmodule

// File: rtl/interp_phase_sequencer.sv
// rtl/interp_phase_sequencer.sv - sample handshake and phase stepping for the polyphase FIR
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid       upstream sample valid
//   in_sample      upstream sample (signed)
//   in_ready       a sample can be accepted this cycle
//   fir_sample     FIR input sample (pass-through of in_sample)
//   fir_en         FIR delay-line load enable (in_valid & in_ready)
//   fir_sel        registered FIR phase select, NULL_SEL while idle
//   out_valid      FIR output is a coherent interpolated sample this cycle
//   out_phase      phase index of that sample
//   underrun_cnt   saturating count of stream breaks
module interp_phase_sequencer
  import interp_pkg::*;
#(
  parameter int PHASE_HOLD = DEF_PHASE_HOLD,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_sample,
  output logic              in_ready,
  output logic [15:0]       fir_sample,
  output logic              fir_en,
  output logic [SEL_W-1:0]  fir_sel,
  output logic              out_valid,
  output logic [SEL_W-1:0]  out_phase,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int HW = (PHASE_HOLD > 1) ? $clog2(PHASE_HOLD) : 1;
  localparam logic [HW-1:0]    HOLD_MAX   = HW'(PHASE_HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_PHASE = SEL_W'(OSF - 1);

  if (PHASE_HOLD < PIPE_LAT - 1) begin : g_bad_hold
    $error("interp_phase_sequencer: PHASE_HOLD must be >= PIPE_LAT-1");
  end
  if (OSF > (2**SEL_W) - 1) begin : g_bad_osf
    $error("interp_phase_sequencer: OSF does not leave room for NULL_SEL");
  end

  seq_state_e       state, state_next;
  logic [HW-1:0]    hold_cnt, hold_next;
  logic [SEL_W-1:0] phase, phase_next;
  logic [SEL_W-1:0] sel_next;
  logic [CNT_W-1:0] cnt_next;
  logic             end_of_sample;
  logic             accept;
  logic             push_valid;

  // Last hold cycle of the last phase: the FIR is still multiplying the old
  // delay line, so a new sample may be loaded without disturbing this output.
  assign end_of_sample = (state == RUN) && (hold_cnt == HOLD_MAX) && (phase == LAST_PHASE);
  assign accept        = in_valid & in_ready;
  assign fir_en        = accept;
  assign fir_sample    = in_sample;
  assign push_valid    = (state == RUN) && (hold_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      phase        <= '0;
      fir_sel      <= NULL_SEL;
      underrun_cnt <= '0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      phase        <= phase_next;
      fir_sel      <= sel_next;
      underrun_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    phase_next = phase;
    sel_next   = fir_sel;
    cnt_next   = underrun_cnt;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        sel_next = NULL_SEL;
        if (in_valid) begin
          state_next = RUN;
          hold_next  = '0;
          phase_next = '0;
          sel_next   = '0;
        end
      end
      RUN: begin
        in_ready = end_of_sample;
        if (hold_cnt == HOLD_MAX) begin
          hold_next = '0;
          if (phase == LAST_PHASE) begin
            phase_next = '0;
            if (in_valid) begin
              sel_next = '0;
            end else begin
              state_next = IDLE;
              sel_next   = NULL_SEL;
              if (underrun_cnt != '1) cnt_next = underrun_cnt + 1'b1;
            end
          end else begin
            phase_next = phase + 1'b1;
            sel_next   = phase + 1'b1;
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = NULL_SEL;
      end
    endcase
  end

  interp_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .W     (SEL_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_phase (phase),
    .tag_valid  (out_valid),
    .tag_phase  (out_phase)
  );

endmodule

// File: tb/tb_interp_phase_sequencer.sv
// tb/tb_interp_phase_sequencer.sv - randomized self-checking bench for interp_phase_sequencer
module tb_interp_phase_sequencer;

  localparam int OSF = 16;
  localparam int H   = 3;
  localparam int L   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_sample = '0;

  logic        in_ready, fir_en, out_valid;
  logic [15:0] fir_sample;
  logic [4:0]  fir_sel, out_phase;
  logic [15:0] underrun_cnt;

  logic        s_in_ready, s_fir_en, s_out_valid;
  logic [15:0] s_fir_sample;
  logic [4:0]  s_fir_sel, s_out_phase;
  logic [3:0]  s_underrun_cnt;

  interp_phase_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sample    (in_sample),
    .in_ready     (in_ready),
    .fir_sample   (fir_sample),
    .fir_en       (fir_en),
    .fir_sel      (fir_sel),
    .out_valid    (out_valid),
    .out_phase    (out_phase),
    .underrun_cnt (underrun_cnt)
  );

  interp_phase_sequencer #(.CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sample    (in_sample),
    .in_ready     (s_in_ready),
    .fir_sample   (s_fir_sample),
    .fir_en       (s_fir_en),
    .fir_sel      (s_fir_sel),
    .out_valid    (s_out_valid),
    .out_phase    (s_out_phase),
    .underrun_cnt (s_underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sample accepted at cycle acc selects phase p during
  // acc+1+H*p .. acc+H*(p+1); its output appears L cycles after that start.
  bit busy = 0;
  int acc  = 0;
  int n    = 0;
  int m_cnt = 0;
  int ev [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  task automatic step(input logic v);
    int   d, p;
    logic exp_ready, exp_en, exp_ov;
    int   exp_sel;
    @(negedge clk);
    in_valid  = v;
    in_sample = 16'($urandom);
    #1;
    if (!busy) begin
      exp_ready = 1'b1;
      exp_sel   = OSF;
    end else begin
      d         = n - acc;
      exp_sel   = (d - 1) / H;
      exp_ready = (d == H * OSF);
    end
    exp_en = v & exp_ready;
    exp_ov = ev.exists(n);
    check("in_ready",   32'(in_ready),   32'(exp_ready));
    check("fir_en",     32'(fir_en),     32'(exp_en));
    check("fir_sel",    32'(fir_sel),    32'(exp_sel));
    check("fir_sample", 32'(fir_sample), 32'(in_sample));
    check("out_valid",  32'(out_valid),  32'(exp_ov));
    if (exp_ov) begin
      check("out_phase", 32'(out_phase), 32'(ev[n]));
      ev.delete(n);
    end
    check("underrun_cnt",     32'(underrun_cnt),   32'(m_cnt));
    check("underrun_cnt_sat", 32'(s_underrun_cnt), 32'((m_cnt > 15) ? 15 : m_cnt));
    if (exp_en) begin
      busy = 1;
      acc  = n;
      for (int q = 0; q < OSF; q++) ev[n + 1 + H * q + L] = q;
    end else if (busy && exp_ready) begin
      busy = 0;
      m_cnt++;
    end
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),       32'd1);
    check("rst_fir_sel",   32'(fir_sel),        32'd16);
    check("rst_out_valid", 32'(out_valid),      32'd0);
    check("rst_cnt",       32'(underrun_cnt),   32'd0);
    check("rst_cnt_sat",   32'(s_underrun_cnt), 32'd0);
    busy  = 0;
    m_cnt = 0;
    ev.delete();
    @(negedge clk);
    rst = 1'b0;
    n   = n + 2;
  endtask

  initial begin
    do_reset();

    // single sample then idle
    step(1'b1);
    repeat (60) step(1'b0);

    // continuous streaming, gapless
    repeat (150) step(1'b1);
    repeat (60) step(1'b0);

    // random valid density
    repeat (600) step(1'($urandom_range(0, 99) < 40));
    repeat (20) step(1'($urandom_range(0, 99) < 90));

    // reset in the middle of a stream, then nothing must come out
    step(1'b1);
    repeat (20) step(1'b1);
    do_reset();
    repeat (20) step(1'b0);

    // repeated underruns drive the narrow counter into saturation
    repeat (22) begin
      step(1'b1);
      repeat (48 + $urandom_range(0, 8)) step(1'b0);
    end
    repeat (10) step(1'b0);
    check("final_underrun",     32'(underrun_cnt),   32'd22);
    check("final_underrun_sat", 32'(s_underrun_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
